zero2one_seq_col_average: RTL

- Sequential replacement for the combinational column averager behind a learning layer's back-propagation output.
- Consumes the per-neuron expected-input matrix (M rows of LEN zero2one_t values) one row per handshake, accumulates each column, then divides by M with LEN parallel restoring dividers.
- Emits one averaged LEN-wide expected_in vector to the upstream layer.
- Trades M+W cycles of latency for removing a wide M-input adder tree per column.

---
 rtl/zero2one_seq_col_average_if.sv | 31 +++
 rtl/zero2one_seq_col_average.sv | 120 ++++++++++++
 2 files changed

// File: rtl/zero2one_seq_col_average_if.sv
// zero2one_seq_col_average_if: row-in / average-out handshake bundle.
// The averager is the slave; the producer/consumer side is the master.
interface zero2one_seq_col_average_if #(
  parameter int LEN = 16,
  parameter int W   = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LEN-1:0][W-1:0] in_row;
  logic                  out_valid;
  logic                  out_ready;
  logic [LEN-1:0][W-1:0] out_avg;

  modport slave (
    input  in_valid,
    input  in_row,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_avg
  );

  modport master (
    output in_valid,
    output in_row,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_avg
  );
endinterface

// File: rtl/zero2one_seq_col_average.sv
// zero2one_seq_col_average: sequential column averager for expected_in.
// Rows accumulate per column, then a W-step restoring divide by M rounds half-up.
module zero2one_seq_col_average #(
  parameter int M   = 50,
  parameter int LEN = 16,
  parameter int W   = 16,
  parameter int CW  = (M > 1) ? $clog2(M) : 1,
  parameter int AW  = W + $clog2(M) + 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      flush,
  zero2one_seq_col_average_if.slave bus,
  output logic                      busy,
  output logic [CW-1:0]             row_cnt
);
  localparam int RW = AW - W;
  localparam int DW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] DIVIDE = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam logic [RW:0]    DIVISOR = (RW + 1)'(M);
  localparam logic [AW-1:0]  HALF    = AW'(M / 2);
  localparam logic [CW-1:0]  LAST    = CW'(M - 1);
  localparam logic [DW-1:0]  DLAST   = DW'(W - 1);

  logic [1:0]            state;
  logic [DW-1:0]         div_cnt;
  logic                  out_valid;
  logic [LEN-1:0][W-1:0] out_avg;

  logic [AW-1:0] acc   [LEN];
  logic [AW-1:0] sum   [LEN];
  logic [AW-1:0] step  [LEN];
  logic [RW:0]   trial [LEN];
  logic [RW-1:0] rem   [LEN];

  logic [LEN-1:0]        qbit;
  logic [LEN-1:0][W-1:0] quot;

  logic accept;
  logic last_row;
  logic div_done;

  assign bus.in_ready  = state == ACCUM;
  assign bus.out_valid = out_valid;
  assign bus.out_avg   = out_avg;

  assign busy = (state != ACCUM) || (row_cnt != '0);

  assign accept   = bus.in_valid && (state == ACCUM);
  assign last_row = row_cnt == LAST;
  assign div_done = div_cnt == DLAST;

  // acc doubles as the divide shift register: {remainder, dividend/quotient}
  always_comb begin
    for (int c = 0; c < LEN; c++) begin
      sum[c]   = acc[c] + AW'(bus.in_row[c]);
      trial[c] = acc[c][AW-1:W-1];
      qbit[c]  = trial[c] >= DIVISOR;
      rem[c]   = qbit[c] ? RW'(trial[c] - DIVISOR)
                         : trial[c][RW-1:0];
      step[c]  = {rem[c], acc[c][W-2:0], qbit[c]};
      quot[c]  = step[c][W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ACCUM;
      row_cnt   <= '0;
      div_cnt   <= '0;
      out_valid <= 1'b0;
      out_avg   <= '0;
      for (int c = 0; c < LEN; c++) acc[c] <= '0;
    end else if (flush) begin
      state     <= ACCUM;
      row_cnt   <= '0;
      div_cnt   <= '0;
      out_valid <= 1'b0;
      for (int c = 0; c < LEN; c++) acc[c] <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            if (last_row) begin
              state   <= DIVIDE;
              row_cnt <= '0;
              div_cnt <= '0;
              for (int c = 0; c < LEN; c++) acc[c] <= sum[c] + HALF;
            end else begin
              row_cnt <= row_cnt + CW'(1);
              for (int c = 0; c < LEN; c++) acc[c] <= sum[c];
            end
          end
        end
        DIVIDE: begin
          div_cnt <= div_cnt + DW'(1);
          if (div_done) begin
            state     <= OUTPUT;
            out_valid <= 1'b1;
            out_avg   <= quot;
            for (int c = 0; c < LEN; c++) acc[c] <= '0;
          end else begin
            for (int c = 0; c < LEN; c++) acc[c] <= step[c];
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule
